// File: rtl/opb_dec_pkg.sv
// Shared types and parameter-slicing helpers for the OPB region decoder.
// Region tables are packed NUM_REGIONS*ADDR_W vectors; helpers pull out one field.
package opb_dec_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_ERR    = 2'd3
    } dec_state_e;

    localparam int MAX_REGIONS = 32;
    localparam int MAX_AW      = 32;

    localparam logic [31:0] ERR_DATA_DEF = 32'h0;

    typedef logic [MAX_REGIONS*MAX_AW-1:0] region_vec_t;

    function automatic logic [MAX_AW-1:0] region_field(
        input region_vec_t v,
        input int          i,
        input int          aw
    );
        region_vec_t       s;
        logic [MAX_AW-1:0] m;
        s = v >> (i * aw);
        m = (aw >= MAX_AW) ? '1 : MAX_AW'((64'd1 << aw) - 64'd1);
        return s[MAX_AW-1:0] & m;
    endfunction

    function automatic logic [MAX_AW-1:0] region_base(
        input region_vec_t bases,
        input int          i,
        input int          aw
    );
        return region_field(bases, i, aw);
    endfunction

    function automatic logic [MAX_AW-1:0] region_size(
        input region_vec_t sizes,
        input int          i,
        input int          aw
    );
        return region_field(sizes, i, aw);
    endfunction

endpackage

// File: rtl/opb_region_match.sv
// Combinational window compare plus lowest-index priority encode.
// Compares run at ADDR_W+1 bits so a window ending at 2^ADDR_W cannot wrap.
module opb_region_match
    import opb_dec_pkg::*;
#(
    parameter int NUM_REGIONS = 16,
    parameter int ADDR_W      = 20,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_SIZE = '0,
    parameter int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    localparam region_vec_t BASE_V = region_vec_t'(REGION_BASE);
    localparam region_vec_t SIZE_V = region_vec_t'(REGION_SIZE);

    logic [NUM_REGIONS-1:0] hit_v;
    logic [ADDR_W:0]        a_ext;

    assign a_ext = {1'b0, addr};

    for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_win
        localparam logic [ADDR_W:0] B =
            (ADDR_W+1)'(region_base(BASE_V, i, ADDR_W));
        localparam logic [ADDR_W:0] S =
            (ADDR_W+1)'(region_size(SIZE_V, i, ADDR_W));
        localparam logic [ADDR_W:0] E = B + S;

        assign hit_v[i] = (S != '0) && (a_ext >= B) && (a_ext < E);
    end

    // Walk downwards so the lowest matching index is the one left standing.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (hit_v[i]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/opb_region_decoder.sv
// Registered OPB address decoder and one-hot read-data collector.
// Optional ACCESS timeout is enabled with `define OPB_DEC_TIMEOUT_EN.
module opb_region_decoder
    import opb_dec_pkg::*;
#(
    parameter int NUM_REGIONS = 16,
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 32,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_SIZE = '0,
    parameter int TIMEOUT     = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
    input  logic                          OPB_CLK,
    input  logic                          OPB_RST,
    input  logic                          DEC_RE,
    input  logic                          DEC_WE,
    input  logic [31:0]                   DEC_ADDR,
    input  logic [NUM_REGIONS-1:0]        SLV_RDY,
    input  logic [NUM_REGIONS*DATA_W-1:0] SLV_DI,
    output logic [NUM_REGIONS-1:0]        SEL_RE,
    output logic [NUM_REGIONS-1:0]        SEL_WE,
    output logic [DATA_W-1:0]             DEC_DO,
    output logic                          DEC_ACK,
    output logic                          DEC_ERR,
    output logic [ADDR_W-1:0]             LAST_ERR_ADDR
);

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    dec_state_e state_q;
    dec_state_e state_d;

    logic [IDX_W-1:0]       idx_q;
    logic                   wr_q;
    logic [ADDR_W-1:0]      a;
    logic                   m_hit;
    logic [IDX_W-1:0]       m_idx;
    logic                   req_any;
    logic                   req_ok;
    logic [NUM_REGIONS-1:0] sel_oh;
    logic                   rdy_sel;
    logic [DATA_W-1:0]      rd_mux;
    logic                   tmo_hit;
    logic                   unused_addr;

    assign a           = DEC_ADDR[ADDR_W-1:0];
    assign unused_addr = ^DEC_ADDR;
    assign req_any     = DEC_RE | DEC_WE;
    assign req_ok      = DEC_RE ^ DEC_WE;

    opb_region_match #(
        .NUM_REGIONS (NUM_REGIONS),
        .ADDR_W      (ADDR_W),
        .REGION_BASE (REGION_BASE),
        .REGION_SIZE (REGION_SIZE),
        .IDX_W       (IDX_W)
    ) u_match (
        .addr (a),
        .hit  (m_hit),
        .idx  (m_idx)
    );

    // One-hot select from the registered index; it also drives the data mux.
    always_comb begin
        sel_oh  = '0;
        rdy_sel = 1'b0;
        rd_mux  = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            sel_oh[i] = (idx_q == IDX_W'(i));
            rdy_sel   = rdy_sel | (sel_oh[i] & SLV_RDY[i]);
            rd_mux    = rd_mux
                      | (SLV_DI[i*DATA_W +: DATA_W] & {DATA_W{sel_oh[i]}});
        end
    end

`ifdef OPB_DEC_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;

    always_ff @(posedge OPB_CLK) begin
        if (OPB_RST || state_q != S_ACCESS) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end

    // Counter reads k during the (k+1)th ACCESS cycle.
    assign tmo_hit = (tmo_cnt_q == 16'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    state_d = (req_ok && m_hit) ? S_ACCESS : S_ERR;
                end
            end
            S_ACCESS: begin
                if (rdy_sel) begin
                    state_d = S_DONE;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge OPB_CLK) begin
        if (OPB_RST) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            wr_q          <= 1'b0;
            DEC_DO        <= '0;
            LAST_ERR_ADDR <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE) begin
                idx_q <= m_idx;
                wr_q  <= DEC_WE;
            end
            if (state_d == S_ERR) begin
                DEC_DO        <= ERR_DATA;
                LAST_ERR_ADDR <= a;
            end else if (state_q == S_ACCESS && state_d == S_DONE && !wr_q) begin
                DEC_DO <= rd_mux;
            end
        end
    end

    assign SEL_RE  = (state_q == S_ACCESS && !wr_q) ? sel_oh : '0;
    assign SEL_WE  = (state_q == S_ACCESS &&  wr_q) ? sel_oh : '0;
    assign DEC_ACK = (state_q == S_DONE);
    assign DEC_ERR = (state_q == S_ERR);

endmodule

// File: tb/tb_opb_region_decoder.sv
// Randomized bench for opb_region_decoder against a window-table reference.
// Build with +define+OPB_DEC_TIMEOUT_EN to cover the timeout path.
`timescale 1ns/1ps
module tb_opb_region_decoder;

    localparam int NR  = 16;
    localparam int AW  = 20;
    localparam int DW  = 32;
    localparam int TMO = 4;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    localparam int RB_A [NR] = '{
        'h00000, 'h10000, 'h10800, 'h30000, 0, 'h40000, 0, 'h80000,
        0, 0, 0, 0, 0, 0, 0, 'hFFF00
    };
    localparam int RS_A [NR] = '{
        'h100, 'h1000, 'h1000, 'h28, 0, 0, 0, 'h10000,
        0, 0, 0, 0, 0, 0, 0, 'h100
    };
    localparam int PICK [7] = '{0, 1, 2, 3, 5, 7, 15};

    function automatic logic [NR*AW-1:0] mk_base();
        logic [NR*AW-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[i*AW +: AW] = AW'(RB_A[i]);
        return v;
    endfunction

    function automatic logic [NR*AW-1:0] mk_size();
        logic [NR*AW-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[i*AW +: AW] = AW'(RS_A[i]);
        return v;
    endfunction

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              re = 1'b0;
    logic              we = 1'b0;
    logic [31:0]       addr = '0;
    logic [NR-1:0]     rdy = '0;
    logic [NR*DW-1:0]  di = '0;
    logic [NR-1:0]     sel_re;
    logic [NR-1:0]     sel_we;
    logic [DW-1:0]     dout;
    logic              ack;
    logic              err;
    logic [AW-1:0]     lea;

    opb_region_decoder #(
        .NUM_REGIONS (NR),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .REGION_BASE (mk_base()),
        .REGION_SIZE (mk_size()),
        .TIMEOUT     (TMO),
        .ERR_DATA    (ERRD)
    ) dut (
        .OPB_CLK       (clk),
        .OPB_RST       (rst),
        .DEC_RE        (re),
        .DEC_WE        (we),
        .DEC_ADDR      (addr),
        .SLV_RDY       (rdy),
        .SLV_DI        (di),
        .SEL_RE        (sel_re),
        .SEL_WE        (sel_we),
        .DEC_DO        (dout),
        .DEC_ACK       (ack),
        .DEC_ERR       (err),
        .LAST_ERR_ADDR (lea)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_do;
    logic [19:0] exp_lea;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_region(input logic [19:0] a);
        int ai;
        ai = int'(a);
        for (int i = 0; i < NR; i++) begin
            if (RS_A[i] > 0 && ai >= RB_A[i] && ai < RB_A[i] + RS_A[i])
                return i;
        end
        return -1;
    endfunction

    task automatic chk_done(input string tag, input bit exp_ack,
                            input bit exp_err);
        check({tag, ".ack"}, 64'(ack), 64'(exp_ack));
        check({tag, ".err"}, 64'(err), 64'(exp_err));
        check({tag, ".sre0"}, 64'(sel_re), 64'd0);
        check({tag, ".swe0"}, 64'(sel_we), 64'd0);
        check({tag, ".do"}, 64'(dout), 64'(exp_do));
        check({tag, ".lea"}, 64'(lea), 64'(exp_lea));
    endtask

    task automatic run_access(input logic [19:0] a, input bit r_en,
                              input bit w_en, input int wait_n,
                              input logic [31:0] data, input string tag);
        int          r;
        bit          bad;
        bit          tmo;
        logic [15:0] rv;
        logic [15:0] exp_sel;
        r   = ref_region(a);
        bad = (r_en && w_en) || (r < 0);
        tmo = 1'b0;
        addr = {12'($urandom), a};
        re   = r_en;
        we   = w_en;
        rdy  = '0;
        for (int i = 0; i < NR; i++)
            di[i*DW +: DW] = (i == r) ? data : $urandom;
        @(posedge clk); #1;
        if (bad) begin
            exp_do  = ERRD;
            exp_lea = a;
            @(negedge clk);
            chk_done({tag, ".miss"}, 1'b0, 1'b1);
        end else begin
            exp_sel = 16'd1 << r;
            for (int k = 0; k <= wait_n; k++) begin
                rv    = 16'($urandom);
                rv[r] = (k == wait_n);
                rdy   = rv;
                @(negedge clk);
                check({tag, ".sre"}, 64'(sel_re), 64'(r_en ? exp_sel : 16'd0));
                check({tag, ".swe"}, 64'(sel_we), 64'(w_en ? exp_sel : 16'd0));
                check({tag, ".early"}, 64'({ack, err}), 64'd0);
                if (k == wait_n) break;
`ifdef OPB_DEC_TIMEOUT_EN
                if (k == TMO - 1) begin
                    tmo = 1'b1;
                    break;
                end
`endif
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
            rdy = '0;
            if (tmo) begin
                exp_do  = ERRD;
                exp_lea = a;
            end else if (r_en) begin
                exp_do = data;
            end
            @(negedge clk);
            chk_done(tag, !tmo, tmo);
        end
        @(posedge clk); #1;
        re = 1'b0;
        we = 1'b0;
    endtask

    task automatic reset_check(input string tag);
        check({tag, ".sre"}, 64'(sel_re), 64'd0);
        check({tag, ".swe"}, 64'(sel_we), 64'd0);
        check({tag, ".do"}, 64'(dout), 64'd0);
        check({tag, ".ack"}, 64'(ack), 64'd0);
        check({tag, ".err"}, 64'(err), 64'd0);
        check({tag, ".lea"}, 64'(lea), 64'd0);
    endtask

    task automatic abort_test();
        addr = 32'h0001_0900;
        re   = 1'b1;
        rdy  = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check("ovl.c1", 64'(sel_re), 64'h2);
        @(posedge clk); #1;
        rst = 1'b1;
        rdy = '1;
        @(negedge clk);
        check("ovl.c2", 64'(sel_re), 64'h2);
        @(posedge clk); #1;
        rst  = 1'b0;
        re   = 1'b0;
        rdy  = '0;
        @(negedge clk);
        reset_check("abort");
        exp_do  = '0;
        exp_lea = '0;
        @(posedge clk); @(negedge clk);
        check("abort.noack", 64'({ack, err}), 64'd0);
    endtask

`ifndef OPB_DEC_TIMEOUT_EN
    task automatic stall_test();
        addr = 32'h0003_0004;
        re   = 1'b1;
        rdy  = '0;
        @(posedge clk); #1;
        for (int k = 1; k <= 1001; k++) begin
            @(negedge clk);
            if (k == 1 || k == 500 || k == 1001) begin
                check("stall.sre", 64'(sel_re), 64'h8);
                check("stall.ack", 64'({ack, err}), 64'd0);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        re  = 1'b0;
        @(negedge clk);
        reset_check("stall.rst");
        exp_do  = '0;
        exp_lea = '0;
    endtask
`endif

    initial begin
        logic [19:0] a;
        int          p;
        int          off;
        int          t;
        exp_do  = '0;
        exp_lea = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_check("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        run_access(20'h30024, 1, 0, 0, 32'hA5A5_0001, "rd_r3");
        run_access(20'h30028, 1, 0, 0, 32'h1234_5678, "past_end");
        run_access(20'h00010, 0, 1, 5, 32'h0BAD_0BAD, "wr_r0_w5");
        run_access(20'h30000, 1, 1, 0, 32'h5555_AAAA, "re_we");
        run_access(20'hFFFFF, 1, 0, 2, 32'hC0DE_0015, "top");
        run_access(20'h40000, 1, 0, 0, 32'h0000_0005, "disabled");
        run_access(20'h10FFF, 1, 0, 1, 32'h0000_1FFF, "ovl_r1");
        run_access(20'h11000, 1, 0, 0, 32'h0000_2000, "ovl_r2");
`ifdef OPB_DEC_TIMEOUT_EN
        run_access(20'h30004, 1, 0, 20, 32'h7777_7777, "timeout");
`endif
        abort_test();
`ifndef OPB_DEC_TIMEOUT_EN
        stall_test();
`endif

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = 20'($urandom);
            end else begin
                p   = PICK[$urandom_range(0, 6)];
                off = int'($urandom_range(0, RS_A[p] + 8)) - 4;
                a   = 20'(RB_A[p] + off);
            end
            t = $urandom_range(0, 9);
            run_access(a, t == 0 || t < 5, t == 0 || t >= 5,
                       $urandom_range(0, 6), $urandom, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/opb_region_decoder.md
# opb_region_decoder

Parametrised, registered OPB address decoder and read-data collector for the FPGA register map. Takes one master request (DEC_RE/DEC_WE + DEC_ADDR), decodes it against NUM_REGIONS base/size windows, drives one-hot per-region strobes until the selected slave signals ready, then returns registered read data with a single-cycle acknowledge. Misses, illegal requests and optional timeouts terminate with an error pulse. It replaces tristate read-data muxing with a one-hot registered mux.

## Interface
- NUM_REGIONS, 16: number of decoded windows, 1..32
- ADDR_W, 20: decoded address bits, taken as DEC_ADDR[ADDR_W-1:0]
- DATA_W, 32: read-data width
- REGION_BASE, 0: packed NUM_REGIONS*ADDR_W, base of region i at [i*ADDR_W +: ADDR_W]
- REGION_SIZE, 0: packed NUM_REGIONS*ADDR_W, size of region i; size 0 disables region i
- TIMEOUT, 255: maximum ACCESS cycles before error, 1..65535
- ERR_DATA, 32'h0: DEC_DO value on error
- OPB_CLK  in  1  clock, all logic on rising edge
- OPB_RST  in  1  synchronous active-high reset
- DEC_RE  in  1  read request, held until DEC_ACK/DEC_ERR
- DEC_WE  in  1  write request, held until DEC_ACK/DEC_ERR
- DEC_ADDR  in  32  request address, stable while request held
- SLV_RDY  in  NUM_REGIONS  per-region ready/done
- SLV_DI  in  NUM_REGIONS*DATA_W  per-region read data, region i at [i*DATA_W +: DATA_W]
- SEL_RE  out  NUM_REGIONS  one-hot read strobe
- SEL_WE  out  NUM_REGIONS  one-hot write strobe
- DEC_DO  out  DATA_W  registered read data
- DEC_ACK  out  1  one-cycle completion pulse
- DEC_ERR  out  1  one-cycle error pulse
- LAST_ERR_ADDR  out  ADDR_W  address of most recent errored request

## Operation
- States: IDLE, ACCESS, DONE, ERR.
- IDLE: request sampled when exactly one of DEC_RE/DEC_WE is high. Hit on region i when base_i <= a < base_i+size_i, compared at ADDR_W+1 bits with no wrap. Overlaps resolve to lowest index. Hit -> ACCESS with index and direction registered. Miss, or DEC_RE & DEC_WE both high -> ERR.
- ACCESS: SEL_RE[i] or SEL_WE[i] held high. SLV_RDY[i] high -> DONE, DEC_DO <= SLV_DI[i] on reads. On writes DEC_DO holds its prior value. Ready bits of unselected regions are ignored.
- DONE: DEC_ACK=1, strobes low. Unconditional -> IDLE.
- ERR: DEC_ERR=1, DEC_DO <= ERR_DATA, LAST_ERR_ADDR <= a. Unconditional -> IDLE.
- Master deasserts its request in the cycle after ACK/ERR. A request still high in IDLE is treated as a new access.
- Reset values: state IDLE; SEL_RE/SEL_WE 0; DEC_DO 0; DEC_ACK 0; DEC_ERR 0; LAST_ERR_ADDR 0.
- Reset asserted mid-access: all outputs take reset values at the next edge. No ACK or ERR is issued for the aborted access.

## Timing
- Request sampled at edge 0 -> strobe high in cycle 1.
- SLV_RDY high in cycle 1 -> DEC_ACK and DEC_DO valid in cycle 2. Each extra wait cycle adds one cycle.
- Miss: DEC_ERR in cycle 1.
- Strobes are one-hot or zero in every cycle and never high in DONE or ERR.
- Back-to-back: a new request can be sampled in the first IDLE cycle after DONE/ERR, giving a minimum of 3 cycles per access.

## Configuration
- OPB_DEC_TIMEOUT_EN defined: a 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle. When it reaches TIMEOUT with SLV_RDY[i] low, the next state is ERR. Strobes drop there and LAST_ERR_ADDR is captured.
- OPB_DEC_TIMEOUT_EN undefined: no counter, and ACCESS waits indefinitely for SLV_RDY[i].

## Structure
- Package opb_dec_pkg holds:
  - state enum
  - ERR_DATA default
  - helper function region_base(i) / region_size(i) for slicing the packed parameters
- Sub-module opb_region_match is combinational: address compare plus lowest-index priority encoder, outputting hit and index.
- Top level holds the FSM, registers and optional timeout counter.

## Test plan
- Region 3 base 0x30000 size 0x28, SLV_RDY tied high; read 0x30024 with SLV_DI[3]=0xA5A5_0001 -> SEL_RE=0x8 in cycle 1, DEC_ACK with DEC_DO=0xA5A5_0001 in cycle 2.
- Read 0x30028 (one past end) -> no strobe, DEC_ERR in cycle 1, DEC_DO=ERR_DATA, LAST_ERR_ADDR=0x30028.
- Write to region 0 with SLV_RDY delayed 5 cycles -> SEL_WE=0x1 for 6 cycles, single DEC_ACK, DEC_DO unchanged.
- DEC_RE and DEC_WE both high on a valid address -> DEC_ERR, no strobe.
- OPB_DEC_TIMEOUT_EN with TIMEOUT=4 and SLV_RDY low -> strobe for 4 cycles, then DEC_ERR. Without the macro, strobe persists past 1000 cycles.
- Overlapping regions 1 and 2 with OPB_RST pulsed in cycle 2 of an access -> lowest index (SEL_RE=0x2) chosen, all outputs zero the cycle after reset, no ACK.
